// File: rtl/nibble_seq_adder.sv
`default_nettype none
// ============================================================================
// Module      : nibble_seq_adder
// Description : Adds two NIBBLES*4-bit operands one nibble per cycle through
//               an external combinational 4-bit adder, with a valid/ready
//               handshake on both sides.
//               Optional macro NIBBLE_SEQ_ADDER_OVF_EN enables the signed
//               overflow flag; when undefined Ovf is tied to 0.
// Revision    : 1.0 - initial release
// ============================================================================
module nibble_seq_adder #(
   parameter int NIBBLES = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [4*NIBBLES-1:0]   A,
   input  logic [4*NIBBLES-1:0]   B,
   input  logic                   Cin,
   input  logic                   In_valid,
   output logic                   In_ready,
   output logic [3:0]             Add_A,
   output logic [3:0]             Add_B,
   output logic                   Add_Cin,
   input  logic [3:0]             Add_Sum,
   input  logic                   Add_Cout,
   output logic [4*NIBBLES-1:0]   Sum,
   output logic                   Cout,
   output logic                   Ovf,
   output logic                   Out_valid,
   input  logic                   Out_ready,
   output logic                   Busy
);

   localparam int W    = 4 * NIBBLES;
   localparam int IDXW = $clog2(NIBBLES);
   localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NIBBLES - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t          state_q;
   logic [IDXW-1:0] idx_q;
   logic [W-1:0]    a_q;
   logic [W-1:0]    b_q;
   logic            cin_q;
   logic            carry_q;
   logic [W-1:0]    sum_q;
   logic            cout_q;
   logic            out_valid_q;
   logic            run_d;

   assign run_d = (state_q == S_RUN);

   // The external adder only sees operand slices while a sum is in flight.
   assign Add_A   = run_d ? a_q[4*idx_q +: 4] : 4'd0;
   assign Add_B   = run_d ? b_q[4*idx_q +: 4] : 4'd0;
   assign Add_Cin = run_d ? ((idx_q == '0) ? cin_q : carry_q) : 1'b0;

   assign In_ready  = (state_q == S_IDLE);
   assign Busy      = run_d;
   assign Sum       = sum_q;
   assign Cout      = cout_q;
   assign Out_valid = out_valid_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         idx_q       <= '0;
         a_q         <= '0;
         b_q         <= '0;
         cin_q       <= 1'b0;
         carry_q     <= 1'b0;
         sum_q       <= '0;
         cout_q      <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (In_valid) begin
                  a_q     <= A;
                  b_q     <= B;
                  cin_q   <= Cin;
                  idx_q   <= '0;
                  sum_q   <= '0;
                  state_q <= S_RUN;
               end
            end
            S_RUN: begin
               sum_q[4*idx_q +: 4] <= Add_Sum;
               carry_q             <= Add_Cout;
               if (idx_q == LAST_IDX) begin
                  cout_q      <= Add_Cout;
                  out_valid_q <= 1'b1;
                  state_q     <= S_DONE;
               end else begin
                  idx_q <= idx_q + 1'b1;
               end
            end
            S_DONE: begin
               if (Out_ready) begin
                  out_valid_q <= 1'b0;
                  state_q     <= S_IDLE;
               end
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

`ifdef NIBBLE_SEQ_ADDER_OVF_EN
   logic ovf_q;

   // Signed overflow: like-signed operands producing an opposite-signed result.
   always_ff @(posedge clk) begin
      if (rst) begin
         ovf_q <= 1'b0;
      end else if (run_d && (idx_q == LAST_IDX)) begin
         ovf_q <= (a_q[W-1] == b_q[W-1]) && (Add_Sum[3] != a_q[W-1]);
      end
   end

   assign Ovf = ovf_q;
`else
   assign Ovf = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_nibble_seq_adder.sv
`default_nettype none
// ============================================================================
// Module      : tb_nibble_seq_adder
// Description : Self-checking bench for nibble_seq_adder (NIBBLES=4) with a
//               behavioural model of the external 4-bit adder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_nibble_seq_adder;

`ifdef NIBBLE_SEQ_ADDER_OVF_EN
   localparam bit OVF_EN = 1'b1;
`else
   localparam bit OVF_EN = 1'b0;
`endif

   logic        clk;
   logic        rst;
   logic [15:0] A;
   logic [15:0] B;
   logic        Cin;
   logic        In_valid;
   logic        In_ready;
   logic [3:0]  Add_A;
   logic [3:0]  Add_B;
   logic        Add_Cin;
   logic [3:0]  Add_Sum;
   logic        Add_Cout;
   logic [15:0] Sum;
   logic        Cout;
   logic        Ovf;
   logic        Out_valid;
   logic        Out_ready;
   logic        Busy;
   logic [4:0]  adder_res;

   int errors = 0;
   int checks = 0;

   nibble_seq_adder #(.NIBBLES(4)) dut (
      .clk(clk), .rst(rst), .A(A), .B(B), .Cin(Cin),
      .In_valid(In_valid), .In_ready(In_ready),
      .Add_A(Add_A), .Add_B(Add_B), .Add_Cin(Add_Cin),
      .Add_Sum(Add_Sum), .Add_Cout(Add_Cout),
      .Sum(Sum), .Cout(Cout), .Ovf(Ovf),
      .Out_valid(Out_valid), .Out_ready(Out_ready), .Busy(Busy)
   );

   // External 4-bit adder
   assign adder_res = {1'b0, Add_A} + {1'b0, Add_B} + {4'd0, Add_Cin};
   assign Add_Sum   = adder_res[3:0];
   assign Add_Cout  = adder_res[4];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic        cin;
      logic [15:0] sum;
      logic        cout;
      logic        ovf;
   } vec_t;

   vec_t vecs[7];

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   // Reference: whole-word arithmetic rather than nibble stepping.
   task automatic model(input logic [15:0] a, input logic [15:0] b, input logic cin,
                        output logic [15:0] s, output logic co, output logic ov);
      logic [16:0] full;
      full = {1'b0, a} + {1'b0, b} + {16'd0, cin};
      s  = full[15:0];
      co = full[16];
      ov = OVF_EN && (a[15] == b[15]) && (s[15] != a[15]);
   endtask

   // Called at a negedge in IDLE; returns at a negedge back in IDLE.
   task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic cin,
                         input logic [15:0] es, input logic ec, input logic eo,
                         input string nm);
      int lat;
      check({nm, " in_ready"}, {31'd0, In_ready}, 32'd1);
      A = a; B = b; Cin = cin; In_valid = 1'b1;
      @(negedge clk);
      In_valid = 1'b0;
      check({nm, " busy"}, {31'd0, Busy}, 32'd1);
      lat = 0;
      while (!Out_valid && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      check({nm, " latency"}, lat, 32'd4);
      check({nm, " sum"}, {16'd0, Sum}, {16'd0, es});
      check({nm, " cout"}, {31'd0, Cout}, {31'd0, ec});
      check({nm, " ovf"}, {31'd0, Ovf}, {31'd0, eo});
      Out_ready = 1'b1;
      @(negedge clk);
      Out_ready = 1'b0;
      check({nm, " out_valid cleared"}, {31'd0, Out_valid}, 32'd0);
   endtask

   initial begin
      logic [15:0] ra, rb, es;
      logic        rc, ec, eo;
      int          seen;

      vecs[0] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0};
      vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
      vecs[2] = '{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0};
      vecs[3] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
      vecs[4] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
      vecs[5] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0};
      vecs[6] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};

      rst = 1'b1; A = '0; B = '0; Cin = 1'b0; In_valid = 1'b0; Out_ready = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      check("reset in_ready", {31'd0, In_ready}, 32'd1);
      check("reset busy", {31'd0, Busy}, 32'd0);
      check("reset out_valid", {31'd0, Out_valid}, 32'd0);
      check("reset sum", {16'd0, Sum}, 32'd0);
      check("reset add_a", {28'd0, Add_A}, 32'd0);

      for (int i = 0; i < 7; i++) begin
         run_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sum, vecs[i].cout,
                OVF_EN ? vecs[i].ovf : 1'b0, $sformatf("vec%0d", i));
      end

      // Downstream stall in DONE with a competing In_valid
      A = 16'h0102; B = 16'h0304; Cin = 1'b0; In_valid = 1'b1;
      @(negedge clk);
      In_valid = 1'b0;
      repeat (4) @(negedge clk);
      check("stall out_valid", {31'd0, Out_valid}, 32'd1);
      A = 16'h1111; B = 16'h2222; Cin = 1'b1; In_valid = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("stall sum", {16'd0, Sum}, 32'h0406);
         check("stall cout", {31'd0, Cout}, 32'd0);
         check("stall in_ready", {31'd0, In_ready}, 32'd0);
         check("stall add_a idle", {28'd0, Add_A}, 32'd0);
      end
      Out_ready = 1'b1;
      @(negedge clk);
      Out_ready = 1'b0;
      check("handshake in_ready", {31'd0, In_ready}, 32'd1);
      check("handshake busy", {31'd0, Busy}, 32'd0);
      @(negedge clk);
      In_valid = 1'b0;
      check("second accepted", {31'd0, Busy}, 32'd1);
      seen = 0;
      while (!Out_valid && seen < 20) begin
         @(negedge clk);
         seen++;
      end
      check("second latency", seen, 32'd4);
      check("second sum", {16'd0, Sum}, 32'h3334);
      Out_ready = 1'b1;
      @(negedge clk);
      Out_ready = 1'b0;

      // Reset on the second RUN cycle
      A = 16'hABCD; B = 16'h1111; Cin = 1'b0; In_valid = 1'b1;
      @(negedge clk);
      In_valid = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("abort in_ready", {31'd0, In_ready}, 32'd1);
      check("abort busy", {31'd0, Busy}, 32'd0);
      check("abort sum", {16'd0, Sum}, 32'd0);
      seen = 0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         if (Out_valid) seen++;
      end
      check("abort no out_valid", seen, 32'd0);

      // Randomized operands against the word-level model
      for (int i = 0; i < 24; i++) begin
         ra = 16'($urandom);
         rb = 16'($urandom);
         rc = 1'($urandom_range(1));
         model(ra, rb, rc, es, ec, eo);
         run_op(ra, rb, rc, es, ec, eo, $sformatf("rnd%0d", i));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/nibble_seq_adder.md
NIBBLE_SEQ_ADDER -- requirements
Module: nibble_seq_adder

Interface
REQ-001 SHALL have parameter NIBBLES, default 4, giving the number of 4-bit slices per operand; operand width is W = 4*NIBBLES, and NIBBLES >= 2.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1; reset is synchronous and active-high.
REQ-004 SHALL have port A, input, W, operand A.
REQ-005 SHALL have port B, input, W, operand B.
REQ-006 SHALL have port Cin, input, 1, the carry into nibble 0.
REQ-007 SHALL have port In_valid, input, 1, which qualifies A/B/Cin.
REQ-008 SHALL have port In_ready, output, 1; it is high only in IDLE.
REQ-009 SHALL have port Add_A, output, 4, the nibble of A driven to the external 4-bit adder.
REQ-010 SHALL have port Add_B, output, 4, the nibble of B driven to the external adder.
REQ-011 SHALL have port Add_Cin, output, 1, the carry driven to the external adder.
REQ-012 SHALL have port Add_Sum, input, 4, the combinational sum returned by the adder.
REQ-013 SHALL have port Add_Cout, input, 1, the combinational carry returned by the adder.
REQ-014 SHALL have port Sum, output, W, the registered full-width result.
REQ-015 SHALL have port Cout, output, 1, the registered final carry.
REQ-016 SHALL have port Ovf, output, 1, the registered two's-complement overflow flag (see Configuration).
REQ-017 SHALL have port Out_valid, output, 1, which qualifies Sum/Cout/Ovf.
REQ-018 SHALL have port Out_ready, input, 1, the downstream accept signal.
REQ-019 SHALL have port Busy, output, 1; it is high in RUN.

Function
REQ-020 SHALL implement the FSM states IDLE, RUN and DONE, plus a nibble index idx of width ceil(log2(NIBBLES)).
REQ-021 SHALL, in IDLE, when In_valid&&In_ready: register A, B and Cin, clear idx to 0, clear the Sum register, and go to RUN.
REQ-022 SHALL, in RUN, drive Add_A=A_reg[4*idx+3:4*idx] and Add_B=B_reg[4*idx+3:4*idx] combinationally from registers, with Add_Cin=Cin_reg when idx==0 and carry_reg otherwise.
REQ-023 SHALL, on each RUN cycle, write Add_Sum into Sum[4*idx+3:4*idx], load carry_reg<=Add_Cout, and increment idx.
REQ-024 SHALL, on the RUN cycle with idx==NIBBLES-1, load Cout<=Add_Cout, set Out_valid<=1 and go to DONE; no idx wrap is ever used.
REQ-025 SHALL make latency exactly NIBBLES cycles: Out_valid rises NIBBLES edges after the accepting edge.
REQ-026 SHALL, in DONE, hold Sum/Cout/Ovf/Out_valid stable until Out_ready==1; on that edge it clears Out_valid and goes to IDLE.
REQ-027 SHALL ignore In_valid outside IDLE, so a new operand is accepted at the earliest one cycle after the DONE handshake (no overlap).
REQ-028 SHALL drive Add_A, Add_B and Add_Cin to 0 in IDLE and DONE.
REQ-029 SHALL ignore Out_ready when Out_valid==0.

Reset
REQ-030 SHALL, when rst==1 at an edge, from any state including mid-RUN: go to IDLE, set idx=0, and set Sum=0, Cout=0, Ovf=0, Out_valid=0 and carry_reg=0; after reset In_ready=1 and Busy=0.
REQ-031 SHALL discard any partial result on reset and emit no Out_valid for the aborted operation.
REQ-032 SHALL give rst priority over every handshake in the same cycle.

Configuration
REQ-033 SHALL, when macro NIBBLE_SEQ_ADDER_OVF_EN is defined, compute Ovf on the final RUN cycle as (A_reg[W-1]==B_reg[W-1]) && (Add_Sum[3]!=A_reg[W-1]) and register it with Cout.
REQ-034 SHALL, when NIBBLE_SEQ_ADDER_OVF_EN is undefined, keep the Ovf port present but tie it constantly to 0, with no overflow logic synthesized.

Verification (NIBBLES=4, bench models the external adder)
REQ-035 SHALL cover A=0x1234, B=0x4321, Cin=0 -> Sum=0x5555, Cout=0, Out_valid exactly 4 cycles after acceptance.
REQ-036 SHALL cover A=0xFFFF, B=0x0001, Cin=0, and A=0xFFFF, B=0x0000, Cin=1 -> Sum=0x0000, Cout=1 in both cases, with the carry propagating through all nibbles.
REQ-037 SHALL cover A=0x7FFF, B=0x0001 -> Sum=0x8000, Cout=0, Ovf=1 with NIBBLE_SEQ_ADDER_OVF_EN and Ovf=0 without; A=0x8000, B=0x8000 -> Sum=0x0000, Cout=1, Ovf=1 (with the macro).
REQ-038 SHALL cover Out_ready held low 3 cycles in DONE -> Sum/Cout stable, In_ready=0, a second In_valid ignored, then accepted 1 cycle after Out_ready handshake.
REQ-039 SHALL cover rst=1 asserted on the 2nd RUN cycle -> next cycle IDLE, In_ready=1, Busy=0, Sum=0, and no Out_valid pulse for the aborted operation.
